maq_m: RTL and testbench

MAQ_M -- requirements
Module: maq_m

---
 rtl/maq_m.sv | 125 ++++++++++++
 tb/tb_maq_m.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/maq_m.sv
// Minutes stage of a digital clock: BCD 00..59 counter advanced by the seconds
// carry in RUN, or adjusted by debounced inc/dec buttons in SET.
module maq_m #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       maqm_clock,
  input  logic       maqm_reset,
  input  logic       maqm_enable,
  input  logic       maqm_add_min,
  input  logic       maqm_set_mode,
  input  logic       maqm_btn_inc,
  input  logic       maqm_btn_dec,
  output logic [3:0] maqm_uni,
  output logic [2:0] maqm_dez,
  output logic       maqm_add_hour,
  output logic       maqm_setting
);

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_SET = 1'b1
  } state_e;

  localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

  state_e state_q, state_d;
  logic   setting_q, setting_d;
  logic   set_meta_q, set_sync_q;

  // Index 0 is the increment button, index 1 the decrement button.
  logic [1:0]       btn_raw;
  logic [1:0]       btn_meta_q, btn_sync_q;
  logic [1:0]       db_q, db_d;
  logic [1:0]       pulse_q, pulse_d;
  logic [1:0][15:0] cnt_q, cnt_d;

  logic [3:0] uni_q, uni_d;
  logic [2:0] dez_q, dez_d;
  logic       tick, at_59, adj_inc, adj_dec;

  // State register plus all synchronizer, debouncer and digit flops.
  always_ff @(posedge maqm_clock) begin
    if (!maqm_reset) begin
      state_q    <= ST_RUN;
      setting_q  <= 1'b0;
      set_meta_q <= 1'b0;
      set_sync_q <= 1'b0;
      btn_meta_q <= '0;
      btn_sync_q <= '0;
      db_q       <= '0;
      pulse_q    <= '0;
      cnt_q      <= '0;
      uni_q      <= '0;
      dez_q      <= '0;
    end else begin
      state_q    <= state_d;
      setting_q  <= setting_d;
      set_meta_q <= maqm_set_mode;
      set_sync_q <= set_meta_q;
      btn_meta_q <= btn_raw;
      btn_sync_q <= btn_meta_q;
      db_q       <= db_d;
      pulse_q    <= pulse_d;
      cnt_q      <= cnt_d;
      uni_q      <= uni_d;
      dez_q      <= dez_d;
    end
  end

  always_comb begin
    state_d = set_sync_q ? ST_SET : ST_RUN;
  end

  // Registered so maqm_setting tracks the state register exactly.
  always_comb begin
    setting_d = (state_d == ST_SET);
  end

  always_comb begin
    btn_raw = {maqm_btn_dec, maqm_btn_inc};
    db_d    = db_q;
    cnt_d   = cnt_q;
    for (int unsigned i = 0; i < 2; i++) begin
      if (btn_sync_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_LAST) begin
        db_d[i]  = btn_sync_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
    pulse_d = db_d & ~db_q;
  end

  always_comb begin
    tick    = maqm_enable & maqm_add_min & (state_q == ST_RUN);
    at_59   = (dez_q == 3'd5) && (uni_q == 4'd9);
    adj_inc = (state_q == ST_SET) & pulse_q[0] & ~pulse_q[1];
    adj_dec = (state_q == ST_SET) & pulse_q[1] & ~pulse_q[0];
    uni_d   = uni_q;
    dez_d   = dez_q;
    if (tick || adj_inc) begin
      if (uni_q < 4'd9) begin
        uni_d = uni_q + 4'd1;
      end else begin
        uni_d = '0;
        dez_d = (dez_q < 3'd5) ? dez_q + 3'd1 : '0;
      end
    end else if (adj_dec) begin
      if (uni_q != 4'd0) begin
        uni_d = uni_q - 4'd1;
      end else begin
        uni_d = 4'd9;
        dez_d = (dez_q == 3'd0) ? 3'd5 : dez_q - 3'd1;
      end
    end
  end

  assign maqm_add_hour = maqm_reset & tick & at_59;
  assign maqm_uni      = uni_q;
  assign maqm_dez      = dez_q;
  assign maqm_setting  = setting_q;

endmodule

// File: tb/tb_maq_m.sv
// Directed self-checking bench for the minutes stage with DEBOUNCE_CYCLES=4.
module tb_maq_m;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable, add_min, set_mode, btn_inc, btn_dec;
  logic [3:0] uni;
  logic [2:0] dez;
  logic       add_hour, setting;

  int n_cmp = 0;
  int n_err = 0;

  maq_m #(.DEBOUNCE_CYCLES(4)) dut (
    .maqm_clock   (clk),
    .maqm_reset   (rst_n),
    .maqm_enable  (enable),
    .maqm_add_min (add_min),
    .maqm_set_mode(set_mode),
    .maqm_btn_inc (btn_inc),
    .maqm_btn_dec (btn_dec),
    .maqm_uni     (uni),
    .maqm_dez     (dez),
    .maqm_add_hour(add_hour),
    .maqm_setting (setting)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_min(input string tag, input int exp_min);
    logic [15:0] obs;
    obs = 16'(dez) * 16'd10 + 16'(uni);
    chk(tag, obs, 16'(exp_min));
  endtask

  // Clean press held long enough for one pulse, then released and settled.
  task automatic press_btn(input logic inc, input logic dec);
    btn_inc = inc;
    btn_dec = dec;
    repeat (7) step();
    btn_inc = 1'b0;
    btn_dec = 1'b0;
    repeat (8) step();
  endtask

  task automatic do_tick(input string tag, input logic exp_hour);
    enable  = 1'b1;
    add_min = 1'b1;
    #1;
    chk(tag, 16'(add_hour), 16'(exp_hour));
    step();
    enable  = 1'b0;
    add_min = 1'b0;
  endtask

  localparam logic [9:0] BOUNCE = 10'b1100110011;

  initial begin
    rst_n = 1'b0; enable = 1'b0; add_min = 1'b0;
    set_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    repeat (2) step();
    chk_min("reset_min", 0);
    chk("reset_setting", 16'(setting), 16'd0);
    chk("reset_add_hour", 16'(add_hour), 16'd0);
    rst_n = 1'b1;
    step();

    // Sixty consecutive ticks wrap 00..59..00.
    for (int i = 0; i < 60; i++) begin
      enable = 1'b1; add_min = 1'b1;
      #1;
      chk("count_add_hour", 16'(add_hour), (i == 59) ? 16'd1 : 16'd0);
      step();
      chk_min("count_min", (i + 1) % 60);
    end
    enable = 1'b0; add_min = 1'b0;
    step();
    chk_min("idle_hold", 0);

    // Set-mode synchronizer latency: state changes on the third edge.
    set_mode = 1'b1;
    repeat (2) step();
    chk("set_sync_edge2", 16'(setting), 16'd0);
    step();
    chk("set_sync_edge3", 16'(setting), 16'd1);

    // Dec from 00 wraps to 59 exactly at edge 7, no carry.
    btn_dec = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step();
      chk("dec_wrap_add_hour", 16'(add_hour), 16'd0);
      chk_min("dec_wrap_min", (e >= 7) ? 59 : 0);
    end
    btn_dec = 1'b0;
    repeat (8) step();
    btn_inc = 1'b1;
    repeat (6) step();
    chk_min("inc_wrap_edge6", 59);
    step();
    chk_min("inc_wrap_edge7", 0);
    chk("inc_wrap_add_hour", 16'(add_hour), 16'd0);
    btn_inc = 1'b0;
    repeat (8) step();

    // Bouncing inc: only the stable level counts, update 6 edges after its first sample.
    for (int e = 0; e < 10; e++) begin
      btn_inc = BOUNCE[9 - e];
      step();
      chk_min("bounce_during", 0);
    end
    btn_inc = 1'b1;
    repeat (4) step();
    chk_min("bounce_edge14", 0);
    step();
    chk_min("bounce_edge15", 1);
    repeat (10) step();
    chk_min("bounce_single", 1);
    btn_inc = 1'b0;
    repeat (8) step();

    press_btn(1'b1, 1'b1);
    chk_min("conflict_both", 1);

    press_btn(1'b0, 1'b1);
    chk_min("dec_to_00", 0);
    press_btn(1'b0, 1'b1);
    chk_min("dec_to_59", 59);

    do_tick("set_tick_add_hour", 1'b0);
    chk_min("set_tick_masked", 59);

    set_mode = 1'b0;
    repeat (3) step();
    chk("back_to_run", 16'(setting), 16'd0);
    do_tick("run_tick_add_hour", 1'b1);
    chk_min("run_tick_wrap", 0);

    press_btn(1'b1, 1'b0);
    chk_min("inc_in_run", 0);

    for (int i = 0; i < 37; i++) do_tick("to37_add_hour", 1'b0);
    chk_min("at_37", 37);

    // Reset lands at debounce count 2 with inc and set_mode still held.
    set_mode = 1'b1;
    repeat (3) step();
    chk("set_before_reset", 16'(setting), 16'd1);
    btn_inc = 1'b1;
    repeat (4) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk_min("mid_reset_min", 0);
    chk("mid_reset_setting", 16'(setting), 16'd0);
    repeat (2) step();
    chk("resync_edge7", 16'(setting), 16'd0);
    step();
    chk("resync_edge8", 16'(setting), 16'd1);
    repeat (3) step();
    chk_min("post_reset_edge11", 0);
    step();
    chk_min("post_reset_edge12", 1);
    btn_inc = 1'b0;
    set_mode = 1'b0;
    repeat (8) step();

    // Reset wins over a tick at 59 and blanks the carry.
    for (int i = 0; i < 58; i++) do_tick("to59_add_hour", 1'b0);
    chk_min("at_59", 59);
    enable = 1'b1; add_min = 1'b1; rst_n = 1'b0;
    #1;
    chk("reset_blocks_add_hour", 16'(add_hour), 16'd0);
    step();
    chk_min("reset_over_tick", 0);
    enable = 1'b0; add_min = 1'b0; rst_n = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
